nios_core_onchip_memory_arbiter: RTL and testbench

NIOS_CORE_ONCHIP_MEMORY_ARBITER -- requirements
Module: nios_core_onchip_memory_arbiter

---
 rtl/nios_core_onchip_memory_arbiter.sv | 118 +++++++++++
 tb/tb_nios_core_onchip_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_core_onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Grant is combinational so an accepted master sees waitrequest low in the
// same cycle. Read data returns one cycle after issue, and a one-entry owner
// register steers readdatavalid back to the master that issued the read.
module nios_core_onchip_memory_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // master 0
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   // master 1
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   // memory
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   logic r_last_grant;   // master that received the most recent access
   logic r_rd_vld;       // a read was issued last cycle
   logic r_rd_id;        // which master issued it

   logic w_req0;
   logic w_req1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_issue;
   logic w_is_write;

   // A write request takes precedence when read and write are both asserted.
   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   // Round-robin: under contention the master that was not served last wins.
   // Reset blocks every grant so no access can leak out while reset is high.
   assign w_gnt0  = ~reset & w_req0 & (~w_req1 | r_last_grant);
   assign w_gnt1  = ~reset & w_req1 & (~w_req0 | ~r_last_grant);
   assign w_issue = w_gnt0 | w_gnt1;
   assign w_is_write = w_gnt1 ? m1_write : m0_write;

   assign m0_waitrequest = ~w_gnt0;
   assign m1_waitrequest = ~w_gnt1;

   // Both masters see the memory output; only readdatavalid marks ownership.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = r_rd_vld & ~r_rd_id;
   assign m1_readdatavalid = r_rd_vld &  r_rd_id;

   // Steer the granted master onto the memory port; park it quietly when idle.
   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_byteenable = '1;
      mem_writedata  = '0;
      if (w_gnt0) begin
         mem_chipselect = 1'b1;
         mem_write      = m0_write;
         mem_address    = m0_address;
         mem_byteenable = m0_byteenable;
         mem_writedata  = m0_writedata;
      end else if (w_gnt1) begin
         mem_chipselect = 1'b1;
         mem_write      = m1_write;
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end
   end

   // Remember who was served last; hold across idle cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= 1'b1;
      end else if (w_issue) begin
         r_last_grant <= w_gnt1;
      end
   end

   // Track the read in flight so its data is flagged to the right master.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_vld <= 1'b0;
         r_rd_id  <= 1'b0;
      end else begin
         r_rd_vld <= w_issue & ~w_is_write;
         r_rd_id  <= w_gnt1;
      end
   end

   // Byte enables are consumed only by the memory; this keeps BE_W meaningful.
   if (BE_W * 8 != DATA_W) begin : g_bad_width
      $error("DATA_W must be a multiple of 8");
   end

endmodule

// File: tb/tb_nios_core_onchip_memory_arbiter.sv
// Directed bench for the two-master memory arbiter with a behavioural
// 1024 x 32 synchronous memory (registered read, byte-enabled write).
module tb_nios_core_onchip_memory_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [3:0]        m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [31:0]       m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [31:0]       m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect, mem_write;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata;

   int checks = 0;
   int errors = 0;
   int g0, g1;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   nios_core_onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   // Synchronous memory: write updates array, read registers the array word.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= mem[mem_address];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic no_req();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[5] = 32'hA5A50005;
      mem[6] = 32'h00000006;
      reset = 1;
      no_req();
      m0_address = 10'd5; m1_address = 10'd6;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_writedata = 32'h0; m1_writedata = 32'h0;

      // Reset: requests present but nothing accepted
      repeat (2) @(posedge clk);
      #2;
      m0_read = 1; m1_read = 1;
      #1;
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_mwr", mem_write, 0);
      chk("rst_m0_rdv", m0_readdatavalid, 0);
      chk("rst_m1_rdv", m1_readdatavalid, 0);

      // First contention after reset: m0 first, then m1
      reset = 0;
      #1;
      chk("c0_m0_wait", m0_waitrequest, 0);
      chk("c0_m1_wait", m1_waitrequest, 1);
      chk("c0_cs", mem_chipselect, 1);
      chk("c0_addr", mem_address, 5);
      cyc();
      m0_read = 0;
      #1;
      chk("c1_m1_wait", m1_waitrequest, 0);
      chk("c1_addr", mem_address, 6);
      chk("c1_m0_rdv", m0_readdatavalid, 1);
      chk("c1_m1_rdv", m1_readdatavalid, 0);
      chk("c1_m0_data", m0_readdata, 32'hA5A50005);
      cyc();
      no_req();
      #1;
      chk("c2_m1_rdv", m1_readdatavalid, 1);
      chk("c2_m0_rdv", m0_readdatavalid, 0);
      chk("c2_m1_data", m1_readdata, 32'h00000006);
      chk("idle_cs", mem_chipselect, 0);
      chk("idle_mwr", mem_write, 0);
      chk("idle_be", mem_byteenable, 4'hF);

      // Continuous contention for 8 cycles: strict alternation
      g0 = 0; g1 = 0;
      m0_read = 1; m1_read = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("rr_m0_wait", m0_waitrequest, (i % 2 == 0) ? 0 : 1);
         chk("rr_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
         if (i > 0) begin
            chk("rr_m0_rdv", m0_readdatavalid, (i % 2 == 1) ? 1 : 0);
            chk("rr_m1_rdv", m1_readdatavalid, (i % 2 == 0) ? 1 : 0);
            chk("rr_data", m0_readdata, (i % 2 == 1) ? 32'hA5A50005 : 32'h00000006);
         end
         if (!m0_waitrequest) g0++;
         if (!m1_waitrequest) g1++;
         cyc();
      end
      no_req();
      #1;
      chk("rr_g0", g0, 4);
      chk("rr_g1", g1, 4);
      chk("rr_last_m1_rdv", m1_readdatavalid, 1);

      // m0 writes 0x3FF, m1 reads it the next cycle
      cyc();
      m0_address = 10'h3FF; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF; m0_write = 1;
      #1;
      chk("wr_m0_wait", m0_waitrequest, 0);
      chk("wr_mwr", mem_write, 1);
      chk("wr_wdata", mem_writedata, 32'hDEADBEEF);
      chk("wr_addr", mem_address, 10'h3FF);
      cyc();
      m0_write = 0; m1_address = 10'h3FF; m1_read = 1;
      #1;
      chk("raw_m1_wait", m1_waitrequest, 0);
      chk("raw_m0_rdv", m0_readdatavalid, 0);
      chk("raw_m1_rdv", m1_readdatavalid, 0);
      cyc();
      no_req();
      #1;
      chk("raw_m1_rdv2", m1_readdatavalid, 1);
      chk("raw_data", m1_readdata, 32'hDEADBEEF);

      // Byte-lane write, with read+write together treated as a write
      cyc();
      m0_address = 10'h010; m0_writedata = 32'h11223344; m0_byteenable = 4'hF; m0_write = 1;
      cyc();
      m0_write = 0;
      m1_address = 10'h010; m1_writedata = 32'h000000AA; m1_byteenable = 4'h1;
      m1_read = 1; m1_write = 1;
      #1;
      chk("be_mwr", mem_write, 1);
      chk("be_be", mem_byteenable, 4'h1);
      cyc();
      no_req();
      m0_address = 10'h010; m0_read = 1;
      #1;
      chk("be_no_rdv", m1_readdatavalid, 0);
      cyc();
      no_req();
      #1;
      chk("be_rdv", m0_readdatavalid, 1);
      chk("be_data", m0_readdata, 32'h112233AA);

      // Reset right after a read issue suppresses its readdatavalid
      cyc();
      m0_address = 10'd5; m0_read = 1;
      #1;
      chk("rr2_m0_wait", m0_waitrequest, 0);
      cyc();
      m0_read = 0;
      reset = 1;
      #1;
      chk("rr2_m0_rdv", m0_readdatavalid, 0);
      chk("rr2_m0_wait", m0_waitrequest, 1);
      cyc();
      #1;
      chk("rr2_m0_rdv_b", m0_readdatavalid, 0);
      reset = 0;
      m0_read = 1; m1_read = 1; m1_address = 10'd6;
      #1;
      chk("rr2_first_m0", m0_waitrequest, 0);
      chk("rr2_first_m1", m1_waitrequest, 1);
      cyc();
      m0_read = 0;
      #1;
      chk("rr2_then_m1", m1_waitrequest, 0);
      cyc();
      no_req();

      // m1 withdraws while m0 holds the grant
      m0_read = 1; m1_read = 1;
      #1;
      chk("wd_m0_wait", m0_waitrequest, 0);
      chk("wd_m1_wait", m1_waitrequest, 1);
      cyc();
      m1_read = 0;
      #1;
      chk("wd_addr", mem_address, 5);
      chk("wd_m1_wait2", m1_waitrequest, 1);
      cyc();
      m0_read = 0;
      #1;
      chk("wd_m1_rdv", m1_readdatavalid, 0);
      chk("wd_m0_rdv", m0_readdatavalid, 1);
      cyc();
      #1;
      chk("wd_m1_rdv2", m1_readdatavalid, 0);
      m0_read = 1; m1_read = 1;
      #1;
      chk("wd_next_m1", m1_waitrequest, 0);
      chk("wd_next_m0", m0_waitrequest, 1);
      cyc();
      no_req();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
